// File: rtl/sodor_instr_pkg.sv
// Shared definitions for R-type instruction generation: opcode and NOP
// constants, LFSR taps, FSM state type, and the field encoder.
package sodor_instr_pkg;

  localparam logic [6:0]  OPC_OP    = 7'b0110011;
  localparam logic [31:0] NOP_INSN  = 32'h00000013;
  localparam logic [6:0]  F7_ALT    = 7'h20;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  // Generator phases: waiting for start, NOP preamble, R-type stream, parked
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } gen_state_t;

  // One Galois step: shift right, fold taps back in when a 1 falls out
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // Map an LFSR value onto a legal RV32I OP-class instruction
  function automatic logic [31:0] encode_rtype(input logic [31:0] l,
                                               input logic        alt_en,
                                               input logic        allow_rd0);
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [4:0] rd;
    logic [2:0] f3;
    logic [6:0] f7;
    rs2 = l[24:20];
    rs1 = l[19:15];
    f3  = l[14:12];
    rd  = l[11:7];
    if (!allow_rd0 && (rd == 5'd0)) rd = 5'd1;
    // Only ADD/SUB (funct3=0) and SRL/SRA (funct3=5) have an alternate form
    f7 = (alt_en && l[30] && ((f3 == 3'd0) || (f3 == 3'd5))) ? F7_ALT : 7'd0;
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR. Reset loads the seed (zero is mapped to one so the
// register can never lock up); en advances one step. The next value is
// exposed combinationally so the caller can encode it in the same cycle
// the register advances.
module lfsr32_galois
  import sodor_instr_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h00000001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] lfsr_next
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h00000001 : SEED;

  logic [31:0] lfsr_q;

  assign lfsr_next = lfsr_step(lfsr_q);

  // State register: seed on reset, step when enabled, otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED_EFF;
    end else if (en) begin
      lfsr_q <= lfsr_next;
    end
  end

endmodule

// File: rtl/rtype_instr_gen.sv
// Stimulus source for the Sodor 5-stage core and its reference model:
// a NOP preamble, then an LFSR-driven stream of legal R-type instructions,
// then a parked NOP.
//
// Handshake: instr_valid/instr presented by this block, instr_ready by the
// consumer. A word transfers on a rising edge where both are high. While
// valid is high and ready is low, instr and all internal state are frozen;
// ready is ignored while valid is low. Once valid rises it stays high until
// reset.
module rtype_instr_gen
  import sodor_instr_pkg::*;
#(
  parameter logic [31:0] SEED       = 32'h00000001,
  parameter int unsigned NOP_CYCLES = 2,
  parameter int unsigned NUM_INSTR  = 64,
  parameter bit          ALT_EN     = 1'b1,
  parameter bit          ALLOW_RD0  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [15:0] instr_cnt,
  output logic        done
);

  localparam bit          NO_PREAMBLE = (NOP_CYCLES == 0);
  localparam bit          UNBOUNDED   = (NUM_INSTR == 0);
  localparam logic [15:0] NOP_LAST    = NO_PREAMBLE ? 16'd0 : 16'(NOP_CYCLES - 1);
  localparam logic [15:0] NUM_LAST    = UNBOUNDED ? 16'd0 : 16'(NUM_INSTR - 1);

  gen_state_t  state;
  logic [15:0] nop_cnt;
  logic        accept;
  logic        nop_last;
  logic        run_last;
  logic        lfsr_en;
  logic [31:0] lfsr_next;
  logic [31:0] next_word;

  lfsr32_galois #(
    .SEED(SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .en       (lfsr_en),
    .lfsr_next(lfsr_next)
  );

  assign next_word = encode_rtype(lfsr_next, ALT_EN, ALLOW_RD0);

  // Transfer detection and LFSR advance: the LFSR steps exactly when a new
  // R-type word is loaded into the output register
  always_comb begin
    accept   = instr_valid && instr_ready;
    nop_last = (nop_cnt == NOP_LAST);
    run_last = !UNBOUNDED && (instr_cnt == NUM_LAST);
    lfsr_en  = 1'b0;
    case (state)
      ST_IDLE:  lfsr_en = start && NO_PREAMBLE;
      ST_PRIME: lfsr_en = accept && nop_last;
      ST_RUN:   lfsr_en = accept && !run_last;
      default:  lfsr_en = 1'b0;
    endcase
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      nop_cnt     <= 16'd0;
      instr       <= NOP_INSN;
      instr_valid <= 1'b0;
      instr_cnt   <= 16'd0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            instr_valid <= 1'b1;
            nop_cnt     <= 16'd0;
            if (NO_PREAMBLE) begin
              instr <= next_word;
              state <= ST_RUN;
            end else begin
              instr <= NOP_INSN;
              state <= ST_PRIME;
            end
          end
        end
        ST_PRIME: begin
          if (accept) begin
            if (nop_last) begin
              instr <= next_word;
              state <= ST_RUN;
            end else begin
              nop_cnt <= nop_cnt + 16'd1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (run_last) begin
              instr_cnt <= instr_cnt + 16'd1;
              instr     <= NOP_INSN;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else begin
              instr <= next_word;
              // Only reachable in unbounded mode; count sticks at all-ones
              if (instr_cnt != 16'hFFFF) instr_cnt <= instr_cnt + 16'd1;
            end
          end
        end
        default: begin
          instr_valid <= 1'b1;
          instr       <= NOP_INSN;
          done        <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtype_instr_gen.sv
// Bench for rtype_instr_gen: three instances share clock/reset/start.
// dut_a (SEED=1, unbounded) and dut_c (SEED=0, unbounded) share a ready
// and must produce the same stream; dut_b (SEED=1, three instructions)
// exercises the DONE park.
module tb_rtype_instr_gen;

  localparam logic [31:0] NOP      = 32'h00000013;
  localparam int          NOPS     = 2;
  localparam bit          ALT      = 1'b1;
  localparam bit          RD0_OK   = 1'b0;
  localparam int          SHORT_N  = 3;
  localparam int          SOAK_N   = 10000;
  localparam int          SOAK_MAX = 40000;

  // ---------------- clock / reset / DUTs ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ready_a;
  logic        ready_b;
  logic        valid_a, valid_b, valid_c;
  logic [31:0] instr_a, instr_b, instr_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic        done_a, done_b, done_c;

  always #5 clk = ~clk;

  rtype_instr_gen #(
    .SEED(32'h1), .NOP_CYCLES(NOPS), .NUM_INSTR(0), .ALT_EN(ALT), .ALLOW_RD0(RD0_OK)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start), .instr_ready(ready_a),
    .instr_valid(valid_a), .instr(instr_a), .instr_cnt(cnt_a), .done(done_a)
  );

  rtype_instr_gen #(
    .SEED(32'h1), .NOP_CYCLES(NOPS), .NUM_INSTR(SHORT_N), .ALT_EN(ALT), .ALLOW_RD0(RD0_OK)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start), .instr_ready(ready_b),
    .instr_valid(valid_b), .instr(instr_b), .instr_cnt(cnt_b), .done(done_b)
  );

  rtype_instr_gen #(
    .SEED(32'h0), .NOP_CYCLES(NOPS), .NUM_INSTR(0), .ALT_EN(ALT), .ALLOW_RD0(RD0_OK)
  ) dut_c (
    .clk(clk), .reset(reset), .start(start), .instr_ready(ready_a),
    .instr_valid(valid_c), .instr(instr_c), .instr_cnt(cnt_c), .done(done_c)
  );

  // ---------------- reference model ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_lfsr;
  int          m_pre;
  int          m_cnt;
  int          m_racc;
  bit          m_active;

  function automatic logic [31:0] ref_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Field arithmetic straight from the instruction format
  function automatic logic [31:0] ref_encode(input logic [31:0] l);
    longint unsigned v, rs2, rs1, f3, rd, f7;
    v   = l;
    rs2 = (v >> 20) % 32;
    rs1 = (v >> 15) % 32;
    f3  = (v >> 12) % 8;
    rd  = (v >> 7) % 32;
    if (!RD0_OK && rd == 0) rd = 1;
    f7  = (ALT && ((v >> 30) % 2 == 1) && (f3 == 0 || f3 == 5)) ? 32 : 0;
    return 32'(f7 * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
               + f3 * (1 << 12) + rd * (1 << 7) + 51);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset;
    m_lfsr   = 32'h1;
    exp_q.delete();
    m_pre    = 0;
    m_cnt    = 0;
    m_active = 1'b0;
  endtask

  task automatic model_start;
    for (int i = 0; i < NOPS; i++) exp_q.push_back(NOP);
    m_pre    = NOPS;
    m_active = 1'b1;
  endtask

  task automatic refill;
    if (exp_q.size() == 0) begin
      m_lfsr = ref_step(m_lfsr);
      exp_q.push_back(ref_encode(m_lfsr));
    end
  endtask

  task automatic rtype_props(input logic [31:0] w);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = w[31:25];
    f3 = w[14:12];
    check("opcode", 32'(w[6:0]), 32'h33);
    check("f7_legal", 32'((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))), 32'd1);
    check("rd_nonzero", 32'(w[11:7] != 5'd0), 32'd1);
  endtask

  // ---------------- driver tasks ----------------
  // One cycle on dut_a/dut_c: drive at negedge, score, return at posedge
  task automatic drive_cycle(input bit rdy, input bit st);
    @(negedge clk);
    ready_a = rdy;
    start   = st;
    check("valid_a", 32'(valid_a), 32'(m_active));
    check("valid_c", 32'(valid_c), 32'(m_active));
    check("cnt_a", 32'(cnt_a), 32'(m_cnt));
    check("cnt_c", 32'(cnt_c), 32'(m_cnt));
    if (m_active) begin
      refill();
      check("instr_a", instr_a, exp_q[0]);
      check("instr_c", instr_c, exp_q[0]);
      if (rdy) begin
        exp_q.delete(0);
        if (m_pre > 0) begin
          m_pre--;
        end else begin
          if (m_cnt < 65535) m_cnt++;
          m_racc++;
          rtype_props(instr_a);
        end
      end
    end else if (st) begin
      model_start();
    end
    @(posedge clk);
  endtask

  // Reset with start and ready asserted to show reset wins
  task automatic apply_reset;
    @(negedge clk);
    reset   = 1'b1;
    start   = 1'b1;
    ready_a = 1'b1;
    ready_b = 1'b1;
    @(posedge clk);
    #1;
    check("rst_instr_a", instr_a, NOP);
    check("rst_valid_a", 32'(valid_a), 32'd0);
    check("rst_cnt_a", 32'(cnt_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_instr_b", instr_b, NOP);
    check("rst_valid_b", 32'(valid_b), 32'd0);
    check("rst_cnt_b", 32'(cnt_b), 32'd0);
    check("rst_done_b", 32'(done_b), 32'd0);
    check("rst_valid_c", 32'(valid_c), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] bw[SHORT_N];
  logic [31:0] l;
  logic [31:0] b_instr_exp;
  int          b_cnt_exp;
  int          cyc;

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    ready_a = 1'b0;
    ready_b = 1'b0;
    m_racc  = 0;
    model_reset();
    repeat (3) @(posedge clk);
    apply_reset();

    // Directed: preamble, first words, stall, ignored start pulses
    drive_cycle(1'b0, 1'b1);
    #1;
    check("start_valid", 32'(valid_a), 32'd1);
    check("start_nop", instr_a, NOP);
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1);
    #1;
    check("first_rtype", instr_a, 32'h002000B3);
    check("first_cnt", 32'(cnt_a), 32'd0);
    repeat (5) drive_cycle(1'b0, 1'b0);
    #1;
    check("stall_hold", instr_a, 32'h002000B3);
    check("stall_cnt", 32'(cnt_a), 32'd0);
    drive_cycle(1'b1, 1'b0);
    #1;
    check("second_rtype", instr_a, 32'h403000B3);
    check("second_cnt", 32'(cnt_a), 32'd1);
    drive_cycle(1'b1, 1'b1);
    #1;
    check("run_cnt2", 32'(cnt_a), 32'd2);
    check("run_done_low", 32'(done_a), 32'd0);
    repeat (6) drive_cycle(1'($urandom_range(0, 1)), 1'b0);

    // Reset in RUN, then the rerun must reproduce the stream from the seed
    apply_reset();
    drive_cycle(1'b1, 1'b1);
    drive_cycle(1'b1, 1'b1);
    repeat (40) drive_cycle(1'($urandom_range(0, 1)), 1'b0);

    // Bounded instance: three words then a parked NOP
    apply_reset();
    l = 32'h1;
    for (int i = 0; i < SHORT_N; i++) begin
      l = ref_step(l);
      bw[i] = ref_encode(l);
    end
    for (int k = 0; k < 26; k++) begin
      drive_cycle(1'b1, k == 0);
      #1;
      if (k < NOPS) b_instr_exp = NOP;
      else if (k < NOPS + SHORT_N) b_instr_exp = bw[k - NOPS];
      else b_instr_exp = NOP;
      b_cnt_exp = (k <= NOPS) ? 0 : ((k < NOPS + SHORT_N) ? k - NOPS : SHORT_N);
      check("b_instr", instr_b, b_instr_exp);
      check("b_valid", 32'(valid_b), 32'd1);
      check("b_cnt", 32'(cnt_b), 32'(b_cnt_exp));
      check("b_done", 32'(done_b), 32'(k >= NOPS + SHORT_N));
    end

    // Soak with random ready
    apply_reset();
    m_racc = 0;
    drive_cycle(1'b1, 1'b1);
    cyc = 0;
    while (m_racc < SOAK_N && cyc < SOAK_MAX) begin
      drive_cycle($urandom_range(0, 3) != 0, 1'b0);
      cyc++;
    end
    check("soak_accepts", 32'(m_racc >= SOAK_N), 32'd1);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
